// File: rtl/asrv32_memoryaccess_pkg.sv
// Shared opcode and funct3 encodings for the asrv32 memory-access stage.
// Opcode is one-hot; each localparam below is a bit index into it.
package asrv32_memoryaccess_pkg;

  localparam int OPCODE_WIDTH = 11;

  localparam int OP_RTYPE  = 0;
  localparam int OP_ITYPE  = 1;
  localparam int OP_LOAD   = 2;
  localparam int OP_STORE  = 3;
  localparam int OP_BRANCH = 4;
  localparam int OP_JAL    = 5;
  localparam int OP_JALR   = 6;
  localparam int OP_LUI    = 7;
  localparam int OP_AUIPC  = 8;
  localparam int OP_SYSTEM = 9;
  localparam int OP_FENCE  = 10;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

endpackage

// File: rtl/asrv32_load_store_align.sv
// Byte-lane select, store replication, load extraction/extension and
// alignment check for one access; purely combinational.
module asrv32_load_store_align
  import asrv32_memoryaccess_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] read_data_i,
  output logic [3:0]  sel_o,
  output logic [31:0] store_data_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        sext;
  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    is_b    = (funct3_i[1:0] == 2'b00);
    is_h    = (funct3_i[1:0] == 2'b01);
    is_w    = funct3_i[1];
    sext    = ~funct3_i[2];
    shifted = read_data_i >> {offset_i, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = offset_i[1] ? read_data_i[31:16]
                          : read_data_i[15:0];

    sel_o        = '0;
    store_data_o = '0;
    load_data_o  = '0;
    misaligned_o = 1'b0;

    unique case (1'b1)
      is_b: begin
        sel_o        = 4'b0001 << offset_i;
        store_data_o = {4{store_data_i[7:0]}};
        load_data_o  = {{24{sext & byte_v[7]}}, byte_v};
      end
      is_h: begin
        sel_o        = offset_i[1] ? 4'b1100 : 4'b0011;
        store_data_o = {2{store_data_i[15:0]}};
        load_data_o  = {{16{sext & half_v[15]}}, half_v};
        misaligned_o = offset_i[0];
      end
      is_w: begin
        sel_o        = 4'b1111;
        store_data_o = store_data_i;
        load_data_o  = read_data_i;
        misaligned_o = |offset_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/asrv32_memoryaccess.sv
// Memory-access stage: runs one Wishbone read/write per LOAD/STORE,
// stalls the pipeline while the bus is busy, and bounds the wait for ack.
module asrv32_memoryaccess
  import asrv32_memoryaccess_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_memoryaccess_en,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [2:0]              i_funct3,
  input  logic [31:0]             i_result_from_alu,
  input  logic [31:0]             i_rs2_data,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [31:0]             o_wb_addr,
  output logic [31:0]             o_wb_data,
  output logic [3:0]              o_wb_sel,
  input  logic                    i_wb_ack,
  input  logic [31:0]             i_wb_data,
  output logic [31:0]             o_load_data,
  output logic                    o_stall,
  output logic                    o_done,
  output logic                    o_load_misaligned,
  output logic                    o_store_misaligned,
  output logic                    o_bus_err
);

  typedef enum logic {IDLE, BUS} state_e;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [3:0]      sel_q, sel_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [31:0]     ld_q, ld_d;
  logic            done_q, done_d;
  logic            lmis_q, lmis_d;
  logic            smis_q, smis_d;
  logic            berr_q, berr_d;

  logic            is_load;
  logic            is_store;
  logic            is_ls;
  logic            in_bus;
  logic            start;
  logic [2:0]      a_f3;
  logic [1:0]      a_off;
  logic [3:0]      a_sel;
  logic [31:0]     a_wdata;
  logic [31:0]     a_ldata;
  logic            a_mis;
  logic            unused_opcode;

  assign is_load  = i_opcode[OP_LOAD];
  assign is_store = i_opcode[OP_STORE];
  assign is_ls    = is_load | is_store;
  assign in_bus   = (state_q == BUS);
  assign unused_opcode = ^i_opcode;

  // While waiting on the bus the aligner formats read data with the
  // size/offset captured at issue, not whatever the pipeline now presents.
  assign a_f3  = in_bus ? f3_q  : i_funct3;
  assign a_off = in_bus ? off_q : i_result_from_alu[1:0];

  asrv32_load_store_align u_align (
    .funct3_i     (a_f3),
    .offset_i     (a_off),
    .store_data_i (i_rs2_data),
    .read_data_i  (i_wb_data),
    .sel_o        (a_sel),
    .store_data_o (a_wdata),
    .load_data_o  (a_ldata),
    .misaligned_o (a_mis)
  );

  assign start = (state_q == IDLE) & i_memoryaccess_en
               & is_ls & ~a_mis;
  assign o_stall = start | in_bus;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    f3_d    = f3_q;
    off_d   = off_q;
    ld_d    = ld_q;
    done_d  = 1'b0;
    lmis_d  = 1'b0;
    smis_d  = 1'b0;
    berr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_memoryaccess_en) begin
          if (is_ls && a_mis) begin
            done_d = 1'b1;
            lmis_d = is_load;
            smis_d = ~is_load;
          end else if (is_ls) begin
            state_d = BUS;
            cnt_d   = '0;
            cyc_d   = 1'b1;
            we_d    = ~is_load;
            addr_d  = {i_result_from_alu[31:2], 2'b00};
            sel_d   = a_sel;
            data_d  = is_load ? 32'd0 : a_wdata;
            f3_d    = i_funct3;
            off_d   = i_result_from_alu[1:0];
          end else begin
            done_d = 1'b1;
          end
        end
      end
      BUS: begin
        // Ack wins over a simultaneous timeout.
        if (i_wb_ack) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) ld_d = a_ldata;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      ld_q    <= '0;
      done_q  <= 1'b0;
      lmis_q  <= 1'b0;
      smis_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      lmis_q  <= lmis_d;
      smis_q  <= smis_d;
      berr_q  <= berr_d;
    end
  end

  assign o_wb_cyc           = cyc_q;
  assign o_wb_stb           = cyc_q;
  assign o_wb_we            = we_q;
  assign o_wb_addr          = addr_q;
  assign o_wb_data          = data_q;
  assign o_wb_sel           = sel_q;
  assign o_load_data        = ld_q;
  assign o_done             = done_q;
  assign o_load_misaligned  = lmis_q;
  assign o_store_misaligned = smis_q;
  assign o_bus_err          = berr_q;

endmodule
